// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and width constants for the logic_unit_pipe slice.
package logic_unit_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      LOP_AND     = 3'd0,
      LOP_OR      = 3'd1,
      LOP_XOR     = 3'd2,
      LOP_ANDN    = 3'd3,
      LOP_ORN     = 3'd4,
      LOP_XNOR    = 3'd5,
      LOP_PASS_A  = 3'd6,
      LOP_ILLEGAL = 3'd7
   } lop_e;

endpackage

// File: rtl/lop_bit.sv
// Single-bit logic evaluator; the undefined opcode yields 0.
module lop_bit
   import logic_unit_pkg::*;
(
   input  logic [OP_W-1:0] op,
   input  logic            a,
   input  logic            b,
   output logic            r
);

   always_comb begin
      r = 1'b0;
      case (lop_e'(op))
         LOP_AND:    r = a & b;
         LOP_OR:     r = a | b;
         LOP_XOR:    r = a ^ b;
         LOP_ANDN:   r = a & ~b;
         LOP_ORN:    r = a | ~b;
         LOP_XNOR:   r = ~(a ^ b);
         LOP_PASS_A: r = a;
         default:    r = 1'b0;
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with synchronous flush.
// Optional zero flag output enabled by defining LOGIC_UNIT_ZFLAG_EN.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int OP_W  = logic_unit_pkg::OP_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_illegal
`ifdef LOGIC_UNIT_ZFLAG_EN
   ,
   output logic             out_zero
`endif
);

   logic             s1_valid;
   logic [OP_W-1:0]  s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s2_valid;
   logic [WIDTH-1:0] s2_next;
   logic             s1_adv;
   logic             s2_adv;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else if (flush) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (s2_adv) s2_valid <= s1_valid;
      end
   end

   // Operand registers carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (s1_adv && in_valid) begin
         s1_op <= in_op;
         s1_a  <= in_a;
         s1_b  <= in_b;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      lop_bit u_bit (
         .op (s1_op),
         .a  (s1_a[i]),
         .b  (s1_b[i]),
         .r  (s2_next[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_result  <= '0;
         out_illegal <= 1'b0;
      end else if (s2_adv && s1_valid) begin
         out_result  <= s2_next;
         out_illegal <= (s1_op == LOP_ILLEGAL);
      end
   end

`ifdef LOGIC_UNIT_ZFLAG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                    out_zero <= 1'b0;
      else if (s2_adv && s1_valid)   out_zero <= ~|s2_next;
   end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomized and directed bench for logic_unit_pipe against a queue-based beat model.
// Zero-flag checks are compiled in when LOGIC_UNIT_ZFLAG_EN is defined.
module tb_logic_unit_pipe;

   localparam int W = 64;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    in_op = '0;
   logic [W-1:0]  in_a = '0;
   logic [W-1:0]  in_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_result;
   logic          out_illegal;
`ifdef LOGIC_UNIT_ZFLAG_EN
   logic          out_zero;
`endif

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_illegal (out_illegal)
`ifdef LOGIC_UNIT_ZFLAG_EN
      ,
      .out_zero    (out_zero)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] r;
      logic         ill;
      int           age;
   } beat_t;

   beat_t q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return a & ~b;
         3'd4:    return a | ~b;
         3'd5:    return ~(a ^ b);
         3'd6:    return a;
         default: return '0;
      endcase
   endfunction

   // Called at posedge+1; drives one cycle, checks outputs, advances the model past the next edge.
   task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ordy, input logic fl,
                       output logic accepted);
      logic  exp_ov, exp_ir;
      beat_t nb;
      in_valid  = v;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      out_ready = ordy;
      flush     = fl;
      #3;
      exp_ov = (q.size() > 0) && (q[0].age >= 1);
      exp_ir = !(q.size() == 2 && !ordy);
      check("out_valid", out_valid, exp_ov);
      check("in_ready", in_ready, exp_ir);
      if (exp_ov) begin
         check("out_result", out_result, q[0].r);
         check("out_illegal", out_illegal, q[0].ill);
`ifdef LOGIC_UNIT_ZFLAG_EN
         check("out_zero", out_zero, q[0].r == '0);
`endif
      end
      accepted = v && exp_ir && !fl;
      if (exp_ov && ordy) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (accepted) begin
         nb.r   = ref_result(op, a, b);
         nb.ill = (op == 3'd7);
         nb.age = 0;
         q.push_back(nb);
      end
      if (fl) q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic ordy);
      logic acc;
      step(1'b0, 3'd0, '0, '0, ordy, 1'b0, acc);
   endtask

   logic [W-1:0] exp33 [8];

   initial begin
      logic acc;
      logic [W-1:0] ra, rb;
      int idx;

      exp33[0] = {8{8'h88}}; exp33[1] = {8{8'hEE}}; exp33[2] = {8{8'h66}};
      exp33[3] = {8{8'h22}}; exp33[4] = {8{8'hBB}}; exp33[5] = {8{8'h99}};
      exp33[6] = {8{8'hAA}}; exp33[7] = '0;

      // reset state
      #12;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_result", out_result, '0);
      check("rst_out_illegal", out_illegal, 1'b0);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // single XOR beat, two cycles latency
      step(1'b1, 3'd2, 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0, acc);
      idle(1'b1);
      check("xor_valid", out_valid, 1'b1);
      check("xor_result", out_result, 64'hF0F0_0F0F_F0F0_0F0F);
      check("xor_illegal", out_illegal, 1'b0);
      idle(1'b1);

      // back-to-back all opcodes
      for (int i = 0; i < 10; i++) begin
         if (i >= 2) begin
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_result", out_result, exp33[i-2]);
            check("b2b_illegal", out_illegal, (i == 9));
         end
         step(i < 8, 3'(i), {16{4'hA}}, {16{4'hC}}, 1'b1, 1'b0, acc);
      end
      idle(1'b1);

      // stall: three beats offered while downstream blocks for five cycles
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         step(idx < 3, 3'(idx), W'(idx + 1) << 8, W'(idx + 5), 1'b0, 1'b0, acc);
         if (acc) idx++;
      end
      check("stall_accepts", idx, 2);
      for (int c = 0; c < 8; c++) begin
         step(idx < 3, 3'(idx), W'(idx + 1) << 8, W'(idx + 5), 1'b1, 1'b0, acc);
         if (acc) idx++;
      end
      check("stall_all_sent", idx, 3);
      check("stall_drained", q.size(), 0);

      // flush with both stages full and a beat offered
      step(1'b1, 3'd1, 64'h1, 64'h2, 1'b0, 1'b0, acc);
      step(1'b1, 3'd1, 64'h3, 64'h4, 1'b0, 1'b0, acc);
      step(1'b1, 3'd1, 64'h5, 64'h6, 1'b0, 1'b1, acc);
      check("flush_valid", out_valid, 1'b0);
      for (int c = 0; c < 4; c++) idle(1'b1);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), ra, rb,
              $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, acc);
      end

      // asynchronous reset mid-stream
      step(1'b1, 3'd6, 64'h55, 64'h0, 1'b0, 1'b0, acc);
      step(1'b1, 3'd6, 64'h66, 64'h0, 1'b0, 1'b0, acc);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("amid_out_valid", out_valid, 1'b0);
      check("amid_in_ready", in_ready, 1'b1);
      check("amid_out_result", out_result, '0);
      q.delete();
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 3'd2, 64'h1234, 64'h1234, 1'b1, 1'b0, acc);
      check("post_rst_accept", acc, 1'b1);
      idle(1'b1);
      check("zero_beat_valid", out_valid, 1'b1);
      check("zero_beat_result", out_result, '0);
`ifdef LOGIC_UNIT_ZFLAG_EN
      check("zero_flag", out_zero, 1'b1);
`endif
      idle(1'b1);
      idle(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
